// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes per neuron over a window, then picks the max-count neuron.
// Optional early exit when any counter reaches EARLY_THRESH: define SPIKE_DECODER_EARLY_EXIT_EN.
module spike_rate_decoder #(
  parameter int LAYER_SIZE   = 4,
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 16,
  parameter int EARLY_THRESH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [WINDOW_WIDTH-1:0]       window_len_i,
  input  logic [LAYER_SIZE-1:0]         spikes_in_i,
  output logic                          busy_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [$clog2(LAYER_SIZE)-1:0] winner_idx_o,
  output logic [COUNT_WIDTH-1:0]        winner_count_o,
  output logic                          tie_o
);

  localparam int IDX_W  = $clog2(LAYER_SIZE);
  localparam int SCAN_W = $clog2(LAYER_SIZE + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
  localparam logic [COUNT_WIDTH-1:0] EARLY_CNT = COUNT_WIDTH'(EARLY_THRESH);
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]              state_q,   state_d;
  logic [WINDOW_WIDTH-1:0] win_q,     win_d;
  logic [COUNT_WIDTH-1:0]  cnt_q [LAYER_SIZE];
  logic [COUNT_WIDTH-1:0]  cnt_d [LAYER_SIZE];
  logic [SCAN_W-1:0]       scan_q,    scan_d;
  logic [COUNT_WIDTH-1:0]  max_q,     max_d;
  logic [IDX_W-1:0]        max_idx_q, max_idx_d;
  logic                    run_tie_q, run_tie_d;
  logic [IDX_W-1:0]        widx_q,    widx_d;
  logic [COUNT_WIDTH-1:0]  wcnt_q,    wcnt_d;
  logic                    tie_q,     tie_d;
  logic                    valid_q,   valid_d;
  logic                    busy_q,    busy_d;
  logic [COUNT_WIDTH-1:0]  cur_cnt_s;
  logic                    early_hit_s;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    run_tie_d   = run_tie_q;
    widx_d      = widx_q;
    wcnt_d      = wcnt_q;
    tie_d       = tie_q;
    valid_d     = valid_q;
    early_hit_s = 1'b0;
    cur_cnt_s   = cnt_q[scan_q[IDX_W-1:0]];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          win_d  = window_len_i;
          cnt_d  = '{default: '0};
          scan_d = '0;
          widx_d = '0;
          wcnt_d = '0;
          tie_d  = 1'b0;
          if (window_len_i == '0) begin
            state_d = S_COMPARE;
          end else begin
            state_d = S_COUNT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COUNT: begin
        for (int i = 0; i < LAYER_SIZE; i++) begin
          if (spikes_in_i[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
        for (int i = 0; i < LAYER_SIZE; i++) begin
          early_hit_s = early_hit_s | (cnt_d[i] >= EARLY_CNT);
        end
`endif
        win_d = win_q - WINDOW_WIDTH'(1);
        if ((win_q == WINDOW_WIDTH'(1)) || early_hit_s) begin
          state_d = S_COMPARE;
          scan_d  = '0;
        end else begin
          state_d = S_COUNT;
        end
      end

      // One neuron per cycle, then one extra cycle to publish the scan result.
      S_COMPARE: begin
        if (scan_q == SCAN_W'(LAYER_SIZE)) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          widx_d  = max_idx_q;
          wcnt_d  = max_q;
          tie_d   = run_tie_q;
        end else begin
          scan_d = scan_q + SCAN_W'(1);
          if (scan_q == '0) begin
            max_d     = cur_cnt_s;
            max_idx_d = '0;
            run_tie_d = 1'b0;
          end else if (cur_cnt_s > max_q) begin
            max_d     = cur_cnt_s;
            max_idx_d = scan_q[IDX_W-1:0];
            run_tie_d = 1'b0;
          end else if (cur_cnt_s == max_q) begin
            run_tie_d = 1'b1;
          end else begin
            run_tie_d = run_tie_q;
          end
        end
      end

      S_DONE: begin
        if (result_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      for (int i = 0; i < LAYER_SIZE; i++) begin
        cnt_q[i] <= '0;
      end
      scan_q    <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      run_tie_q <= 1'b0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      tie_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      scan_q    <= scan_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      run_tie_q <= run_tie_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      tie_q     <= tie_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign winner_idx_o   = widx_q;
  assign winner_count_o = wcnt_q;
  assign tie_o          = tie_q;

endmodule
